// File: rtl/hex_scan_display.sv
// Scanned driver for N common-anode 7-segment digits: a prescaled digit scan
// with anti-ghost dead time, a frame-atomic display word, leading-zero
// blanking and a global blank. All outputs are registered.
module hex_scan_display #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*N_DIGITS-1:0]   load_value,
  input  logic [N_DIGITS-1:0]     load_dp,
  input  logic                    lzb_en,
  input  logic                    blank,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [N_DIGITS-1:0]     an_n,
  output logic                    frame_tick
);

  localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [PRE_W-1:0]      r_pre;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_lzb;
  logic [4*N_DIGITS-1:0] r_active;
  logic [N_DIGITS-1:0]   r_active_dp;
  logic [4*N_DIGITS-1:0] r_pend;
  logic [N_DIGITS-1:0]   r_pend_dp;
  logic                  r_ready;
  logic [6:0]            r_seg_n;
  logic                  r_dp_n;
  logic [N_DIGITS-1:0]   r_an_n;
  logic                  r_frame_tick;

  logic                  w_slot_end;
  logic                  w_wrap;
  logic                  w_accept;
  logic                  w_dead;
  logic [3:0]            w_nib;
  logic                  w_digit_dp;
  logic [IDX_W-1:0]      w_msnz;
  logic                  w_suppress;
  logic [N_DIGITS-1:0]   w_an;
  logic [6:0]            w_seg;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign w_slot_end = (r_pre == PRE_W'(SCAN_DIV - 1));
  assign w_wrap     = w_slot_end && (r_idx == IDX_W'(N_DIGITS - 1));
  assign w_accept   = load_valid && r_ready;
  assign w_dead     = (r_pre < PRE_W'(BLANK_CYC));

  // Prescaler and digit index; lzb_en is latched as each new slot begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
      r_lzb <= 1'b0;
    end else if (w_slot_end) begin
      r_pre <= '0;
      r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);
      r_lzb <= lzb_en;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Pending slot fill on handshake, commit to active only at frame wrap.
  // An accept can only happen while pending is empty, so it never coincides
  // with a commit; a word accepted on the wrap cycle waits a full frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active    <= '0;
      r_active_dp <= '0;
      r_pend      <= '0;
      r_pend_dp   <= '0;
      r_ready     <= 1'b1;
    end else if (w_accept) begin
      r_pend    <= load_value;
      r_pend_dp <= load_dp;
      r_ready   <= 1'b0;
    end else if (w_wrap && !r_ready) begin
      r_active    <= r_pend;
      r_active_dp <= r_pend_dp;
      r_ready     <= 1'b1;
    end
  end

  // Current digit selection, leading-zero detection and segment decode
  always_comb begin
    w_nib      = '0;
    w_digit_dp = 1'b0;
    w_msnz     = '0;
    w_an       = '1;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib      = r_active[4*k +: 4];
        w_digit_dp = r_active_dp[k];
        w_an[k]    = 1'b0;
      end
      if (r_active[4*k +: 4] != 4'h0) begin
        w_msnz = IDX_W'(k);
      end
    end
    w_suppress = r_lzb && (r_idx > w_msnz);
    w_seg      = w_suppress ? 7'h7F : f_decode(w_nib);
  end

  // Registered pin drivers; anodes held off during dead time or blank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_n      <= 7'h7F;
      r_dp_n       <= 1'b1;
      r_an_n       <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_seg_n      <= w_seg;
      r_dp_n       <= !w_digit_dp;
      r_an_n       <= (blank || w_dead) ? '1 : w_an;
      r_frame_tick <= w_wrap;
    end
  end

  assign load_ready = r_ready;
  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign an_n       = r_an_n;
  assign frame_tick = r_frame_tick;

endmodule
